// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter:
// requester count, owner index width and the FSM state encoding.
package rr_arbiter_4_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arbiter_4_if.sv
// Client <-> arbiter bundle.
//   req           : request vector, bit n = requester n (level)
//   owner_release : current owner is done, sampled only while granted
//   gnt           : one-hot grant, zero when nobody owns the resource
//   gnt_idx       : owner index, meaningful only with gnt_valid
//   gnt_valid     : a grant is active
//   timeout       : one-cycle pulse after a hold-limit forced release
// master = client side, slave = arbiter side.
interface rr_arbiter_4_if;
  import rr_arbiter_4_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               owner_release;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;

  modport master (output req, owner_release,
                  input  gnt, gnt_idx, gnt_valid, timeout);
  modport slave  (input  req, owner_release,
                  output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter_4_dec.sv
// 2-to-4 one-hot decoder for the owner index.
//   idx    : binary owner index
//   onehot : bit idx set, all others clear
module dec2to4_onehot
  import rr_arbiter_4_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);
  assign onehot = NUM_REQ'(1) << idx;
endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with bounded hold time.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : rr_arbiter_4_if.slave (req/owner_release in, grant signals out)
// A grant lasts until the owner releases, drops its request, or has held
// for HOLD_MAX cycles. Every release is followed by one idle cycle before
// the next grant. All outputs are registered.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16,  // 1..255
  parameter int unsigned CW       = 8    // 2**CW > HOLD_MAX
)(
  input  logic         clk,
  input  logic         rst,
  rr_arbiter_4_if.slave bus
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               valid_q, valid_d;
  logic [CW-1:0]      hold_q, hold_d;
  logic               timeout_q, timeout_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] dec_oh;
  logic               hit_limit, norm_rel;

  // First set request searching last+1, last+2, last+3, last (mod 4).
  // Walk from the farthest candidate down so the nearest one wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] cand;
    rr_pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last + IDX_W'(k);
      if (r[cand]) rr_pick = cand;
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    hit_limit = (hold_q == CW'(HOLD_MAX - 1));
    norm_rel  = bus.owner_release | ~bus.req[idx_q];
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          idx_d   = rr_pick(bus.req, last_q);
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        hold_d = hold_q + 1'b1;
        if (norm_rel || hit_limit) begin
          last_d    = idx_q;
          idx_d     = '0;
          valid_d   = 1'b0;
          hold_d    = '0;
          state_d   = IDLE;
          // Only a pure hold-limit release counts as a timeout.
          timeout_d = hit_limit & ~norm_rel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode the next owner so gnt is registered alongside gnt_idx.
  dec2to4_onehot u_dec (
    .idx    (idx_d),
    .onehot (dec_oh)
  );
  assign gnt_d = dec_oh & {NUM_REQ{valid_d}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);  // requester 0 first after reset
      valid_q   <= 1'b0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      gnt_q     <= gnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule
